// File: rtl/switch_debouncer.sv
// switch_debouncer: conditions a raw, bouncing switch level into a clean
// synchronous level with single-cycle edge pulses. A free-running prescaler
// supplies a slow enable tick; the input must disagree with the debounced
// level for STABLE_COUNT consecutive ticks before the level changes.
module switch_debouncer #(
  parameter int DIV_WIDTH    = 17,
  parameter int STABLE_COUNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic d_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic tick,
  output logic busy
);

  // One extra bit of margin is never needed; STABLE_COUNT=1 still gets a 1-bit counter.
  localparam int CW = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_COUNT - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CHECK = 1'b1;

  logic                 s1;
  logic                 s2;
  logic [DIV_WIDTH-1:0] prescale;
  logic [0:0]           state;
  logic [CW-1:0]        count;

  // Two-flop synchronizer; only s2 is used by downstream logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sw_in;
      s2 <= s1;
    end
  end

  // Free-running prescaler; tick is registered, high the cycle after all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale <= '0;
      tick     <= 1'b0;
    end else begin
      prescale <= prescale + 1'b1;
      tick     <= &prescale;
    end
  end

  // Qualification FSM: a reversion aborts even when a tick coincides with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      d_out      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (s2 != d_out) begin
            state <= CHECK;
            count <= '0;
          end
        end
        CHECK: begin
          if (s2 == d_out) begin
            state <= IDLE;
            count <= '0;
          end else if (tick) begin
            if (count == LAST) begin
              d_out      <= s2;
              rise_pulse <= s2;
              fall_pulse <= ~s2;
              state      <= IDLE;
              count      <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign busy = (state == CHECK);

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer with DIV_WIDTH=4, STABLE_COUNT=3.
// Stimulus schedules expected pulses and point checks keyed by the number of
// clk edges since the last reset release; a monitor pops and compares them.
module tb_switch_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic sw_in;
  logic d_out;
  logic rise_pulse;
  logic fall_pulse;
  logic tick;
  logic busy;

  switch_debouncer #(.DIV_WIDTH(4), .STABLE_COUNT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_in      (sw_in),
    .d_out      (d_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .tick       (tick),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Edges since reset release (0 while in reset).
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  localparam int SIG_BUSY  = 0;
  localparam int SIG_DOUT  = 1;
  localparam int SIG_RISE  = 2;
  localparam int SIG_FALL  = 3;
  localparam int SIG_COUNT = 4;

  typedef struct { int cyc; int sig; int val; } chk_t;
  typedef struct { int cyc; bit rise; } pulse_t;

  chk_t   chk_q[$];
  pulse_t pulse_q[$];

  logic done       = 1'b0;
  logic probe_flag = 1'b0;
  event probe_ev;

  int total = 0;
  int bad   = 0;
  int gcyc  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cyc=%0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int sig_val(input int s);
    case (s)
      SIG_BUSY:  return int'(busy);
      SIG_DOUT:  return int'(d_out);
      SIG_RISE:  return int'(rise_pulse);
      SIG_FALL:  return int'(fall_pulse);
      default:   return int'(dut.count);
    endcase
  endfunction

  function automatic string sig_name(input int s);
    case (s)
      SIG_BUSY:  return "busy";
      SIG_DOUT:  return "d_out";
      SIG_RISE:  return "rise_pulse";
      SIG_FALL:  return "fall_pulse";
      default:   return "count";
    endcase
  endfunction

  // Monitor / scoreboard.
  initial begin
    chk_t   c;
    pulse_t p;
    forever begin
      @(negedge clk or probe_ev);
      if (probe_flag) begin
        check("midreset_busy",  int'(busy), 0);
        check("midreset_count", int'(dut.count), 0);
        check("midreset_dout",  int'(d_out), 0);
        check("midreset_pulse", int'(rise_pulse | fall_pulse), 0);
      end else begin
        gcyc++;
        if (rst) begin
          check("reset_dout",  int'(d_out), 0);
          check("reset_busy",  int'(busy), 0);
          check("reset_tick",  int'(tick), 0);
          check("reset_pulse", int'(rise_pulse | fall_pulse), 0);
        end else begin
          check("tick", int'(tick), ((cyc % 16 == 0) && (cyc != 0)) ? 1 : 0);
          while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
            c = chk_q.pop_front();
            if (c.cyc < cyc) check({"missed_", sig_name(c.sig)}, cyc, c.cyc);
            else             check(sig_name(c.sig), sig_val(c.sig), c.val);
          end
          while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
            p = pulse_q.pop_front();
            check("missing_pulse", 0, 1);
          end
          if (rise_pulse && fall_pulse) check("both_pulses", 1, 0);
          if (rise_pulse || fall_pulse) begin
            if (pulse_q.size() == 0) begin
              check("unexpected_pulse", 1, 0);
            end else begin
              p = pulse_q.pop_front();
              check("pulse_cycle", cyc, p.cyc);
              check("pulse_kind",  int'(rise_pulse), int'(p.rise));
              check("pulse_dout",  int'(d_out), int'(p.rise));
            end
          end
        end
        if (done || gcyc > 3000) begin
          if (!done) check("timeout", gcyc, 3000);
          check("chk_q_drained",   chk_q.size(), 0);
          check("pulse_q_drained", pulse_q.size(), 0);
          $display("test done: total=%0d bad=%0d", total, bad);
          $finish;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    for (int n = 0; n < 600 && cyc != c; n++) step();
  endtask

  task automatic exp_chk(input int c, input int s, input int v);
    chk_t e;
    e.cyc = c; e.sig = s; e.val = v;
    chk_q.push_back(e);
  endtask

  task automatic exp_pulse(input int c, input bit r);
    pulse_t e;
    e.cyc = c; e.rise = r;
    pulse_q.push_back(e);
  endtask

  // Stimulus. Input changes land 1ns after a negedge, i.e. after edge 'cyc'.
  initial begin
    rst   = 1'b1;
    sw_in = 1'b1;
    repeat (5) step();
    rst   = 1'b0;
    sw_in = 1'b0;

    // Bounce: toggle every 5 cycles from cyc 2 through 77, ending low.
    exp_chk(5,  SIG_BUSY, 1);
    exp_chk(10, SIG_BUSY, 0);
    exp_chk(78, SIG_DOUT, 0);
    for (int i = 0; i < 16; i++) begin
      wait_until(2 + 5 * i);
      sw_in = (i % 2 == 0);
    end

    // Clean press at 100: CHECK from 103, ticks seen at 113/129/145.
    wait_until(100);
    sw_in = 1'b1;
    exp_chk(102, SIG_BUSY, 0);
    exp_chk(103, SIG_BUSY, 1);
    exp_chk(144, SIG_DOUT, 0);
    exp_chk(145, SIG_DOUT, 1);
    exp_chk(145, SIG_FALL, 0);
    exp_chk(146, SIG_RISE, 0);
    exp_chk(146, SIG_BUSY, 0);
    exp_pulse(145, 1'b1);

    // Release at 150: CHECK from 153, ticks seen at 161/177/193.
    wait_until(150);
    sw_in = 1'b0;
    exp_chk(192, SIG_DOUT, 1);
    exp_chk(193, SIG_DOUT, 0);
    exp_chk(193, SIG_RISE, 0);
    exp_chk(194, SIG_FALL, 0);
    exp_pulse(193, 1'b0);

    // Abort on tick: count=1 after edge 209; s2 returns to 0 at edge 224
    // while tick is high in cycle 224, so edge 225 must abort.
    wait_until(200);
    sw_in = 1'b1;
    exp_chk(209, SIG_COUNT, 1);
    exp_chk(224, SIG_BUSY,  1);
    exp_chk(224, SIG_COUNT, 1);
    exp_chk(225, SIG_BUSY,  0);
    exp_chk(225, SIG_COUNT, 0);
    exp_chk(226, SIG_DOUT,  0);
    wait_until(222);
    sw_in = 1'b0;

    // Mid-operation reset: count=2 after edge 273, reset pulsed between edges.
    wait_until(240);
    sw_in = 1'b1;
    exp_chk(273, SIG_COUNT, 2);
    exp_chk(273, SIG_BUSY,  1);
    wait_until(276);
    rst = 1'b1;
    #1;
    probe_flag = 1'b1;
    -> probe_ev;
    #1;
    probe_flag = 1'b0;
    rst = 1'b0;
    // Requalify from scratch: CHECK at 3, ticks seen at 17/33/49.
    exp_chk(2,  SIG_BUSY,  0);
    exp_chk(3,  SIG_BUSY,  1);
    exp_chk(3,  SIG_COUNT, 0);
    exp_chk(48, SIG_DOUT,  0);
    exp_chk(49, SIG_DOUT,  1);
    exp_chk(50, SIG_RISE,  0);
    exp_pulse(49, 1'b1);

    wait_until(70);
    done = 1'b1;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
Input conditioner placed directly upstream of the board-level D flip-flop. It takes a raw, asynchronous, bouncing switch or button level and produces a clean, synchronous data level (d_out) that drives the flip-flop's d input. It also produces single-cycle edge pulses. Its slow enable tick replaces ad-hoc clock dividers: downstream logic uses tick as an enable on clk instead of deriving a divided clock.

Parameters:
DIV_WIDTH, 17, prescaler width; tick period = 2^DIV_WIDTH clk cycles
STABLE_COUNT, 4, consecutive ticks the synchronized input must differ from d_out before d_out changes; legal range >= 1

Ports:
clk  input  1  single system clock, rising-edge
rst  input  1  asynchronous, active-high reset
sw_in  input  1  raw switch level, asynchronous to clk, may bounce
d_out  output  1  debounced, synchronous level (feeds flip-flop d)
rise_pulse  output  1  one-cycle pulse when d_out goes 0->1
fall_pulse  output  1  one-cycle pulse when d_out goes 1->0
tick  output  1  one-cycle enable, once per 2^DIV_WIDTH cycles
busy  output  1  high while a candidate change is being qualified (state CHECK)

Behaviour:
- Clocking/reset: one clock (clk); reset rst is asynchronous, active-high. All flops clear immediately when rst rises, independent of clk.
- Reset values: d_out=0, rise_pulse=0, fall_pulse=0, tick=0, busy=0; prescaler=0, both synchronizer flops=0, state=IDLE, stable counter=0.
- Synchronizer: 2-flop chain sw_in -> s1 -> s2. All logic uses s2 only. Latency is 2 clk edges.
- Prescaler: free-running DIV_WIDTH-bit up-counter that wraps naturally. tick is registered and is high in the cycle after the counter equals all-ones. With DIV_WIDTH=4, tick is first high 16 cycles after reset release, then every 16 cycles.
- Stable counter width: enough bits to hold STABLE_COUNT-1.
- FSM, two states:
  - IDLE: busy=0. If s2 != d_out, go to CHECK next edge with count=0. Otherwise stay.
  - CHECK: busy=1.
    - Any cycle with s2 == d_out: abort to IDLE and clear count. Abort has priority over a coincident tick.
    - Tick with s2 != d_out and count < STABLE_COUNT-1: count+1.
    - Tick with s2 != d_out and count == STABLE_COUNT-1: on the next edge, d_out<=s2, state=IDLE, count=0, and exactly one of rise_pulse/fall_pulse is high for that one cycle.
- Pulses coincide with the first cycle of the new d_out value. They are never both high and never high for more than one cycle.
- Qualification time: STABLE_COUNT ticks counted from CHECK entry. Any partial tick period before the first tick is included.
- Glitch shorter than the synchronizer window, or any reversion before qualification: no d_out change, no pulse.
- Reset mid-CHECK: progress is discarded. After release, a held sw_in=1 must requalify from count=0. No pulse is generated by reset assertion or release.
- tick runs continuously, regardless of FSM state.

Test Plan:
(all with DIV_WIDTH=4, STABLE_COUNT=3)
1. Reset: rst=1 with sw_in=1 for 5 cycles -> d_out=0, busy=0, tick=0, pulses=0 throughout. After release, first tick at cycle 16, then every 16 cycles.
2. Clean press: sw_in 0->1 and held -> busy=1 on the 3rd edge after the change. d_out=1 one cycle after the 3rd tick seen in CHECK. rise_pulse=1 for exactly that cycle. fall_pulse stays 0.
3. Bounce: sw_in toggles every 5 cycles for 80 cycles, then settles at 0 -> d_out stays 0, busy toggles, no pulses.
4. Release: from d_out=1, sw_in 1->0 held -> fall_pulse exactly one cycle, d_out=0 after 3 ticks in CHECK, rise_pulse stays 0.
5. Abort on tick: in CHECK with count=1, return sw_in so s2 equals d_out in the same cycle as a tick -> IDLE next edge, count=0, d_out unchanged.
6. Mid-operation reset: in CHECK with count=2, pulse rst high between edges -> busy and count clear immediately (before the next edge). With sw_in held at 1, d_out rises only after 3 full new ticks.
